// File: rtl/sram_port_arbiter_if.sv
// Requester ports A/B and SRAM controller handshake bundle
// for the two-port round-robin SRAM arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              a_wdone;
  logic              a_err;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;
  logic              b_wdone;
  logic              b_err;

  logic [ADDR_W-1:0] o_ctl_address;
  logic [DATA_W-1:0] o_ctl_data;
  logic              o_ctl_rd_strt;
  logic              o_ctl_wr_strt;
  logic [DATA_W-1:0] i_ctl_data;
  logic              i_ctl_data_valid;
  logic              i_ctl_wr_done;
  logic              i_ctl_busy;
  logic              o_arb_busy;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_rvalid, a_wdone, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rvalid, b_wdone, b_err,
    input  o_ctl_address, o_ctl_data,
    input  o_ctl_rd_strt, o_ctl_wr_strt,
    output i_ctl_data, i_ctl_data_valid,
    output i_ctl_wr_done, i_ctl_busy,
    input  o_arb_busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_rvalid, a_wdone, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_rvalid, b_wdone, b_err,
    output o_ctl_address, o_ctl_data,
    output o_ctl_rd_strt, o_ctl_wr_strt,
    input  i_ctl_data, i_ctl_data_valid,
    input  i_ctl_wr_done, i_ctl_busy,
    output o_arb_busy
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of the SRAM controller,
// with a watchdog that aborts transactions that never complete.
module sram_port_arbiter #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                 i_clk,
  input logic                 reset,
  sram_port_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic              we, we_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] wdata, wdata_n;
  logic              rd_strt, rd_n;
  logic              wr_strt, wr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              busy, busy_n;
  logic              a_ack, a_ack_n, b_ack, b_ack_n;
  logic              a_rv, a_rv_n, b_rv, b_rv_n;
  logic              a_wd, a_wd_n, b_wd, b_wd_n;
  logic              a_err, a_err_n, b_err, b_err_n;
  logic [DATA_W-1:0] a_rd, a_rd_n, b_rd, b_rd_n;
  logic [DATA_W-1:0] rsp_data;
  logic              pick_b, done, tmo;

  // last==1 means B was granted last, so A wins a tie
  assign pick_b = bus.b_req & (~bus.a_req | ~last);
  assign done   = we ? bus.i_ctl_wr_done : bus.i_ctl_data_valid;
  assign tmo    = (cnt == TMO_MAX);
  assign rsp_data = done ? bus.i_ctl_data : '0;

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    we_n    = we;
    addr_n  = addr;
    wdata_n = wdata;
    rd_n    = rd_strt;
    wr_n    = wr_strt;
    cnt_n   = cnt;
    a_ack_n = 1'b0;
    b_ack_n = 1'b0;
    a_rv_n  = 1'b0;
    b_rv_n  = 1'b0;
    a_wd_n  = 1'b0;
    b_wd_n  = 1'b0;
    a_err_n = 1'b0;
    b_err_n = 1'b0;
    a_rd_n  = a_rd;
    b_rd_n  = b_rd;
    unique case (state)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          owner_n = pick_b;
          last_n  = pick_b;
          we_n    = pick_b ? bus.b_we : bus.a_we;
          addr_n  = pick_b ? bus.b_addr : bus.a_addr;
          wdata_n = pick_b ? bus.b_wdata : bus.a_wdata;
          rd_n    = ~we_n;
          wr_n    = we_n;
          cnt_n   = '0;
          a_ack_n = ~pick_b;
          b_ack_n = pick_b;
          state_n = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        cnt_n = cnt + 1'b1;
        // completion beats a same-cycle timeout
        if (done | tmo) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = IDLE;
          if (!owner) begin
            a_wd_n  = we;
            a_rv_n  = ~we;
            a_err_n = ~done;
            if (!we) a_rd_n = rsp_data;
          end else begin
            b_wd_n  = we;
            b_rv_n  = ~we;
            b_err_n = ~done;
            if (!we) b_rd_n = rsp_data;
          end
        end else if (state == ISSUE && bus.i_ctl_busy) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rd_strt <= 1'b0;
      wr_strt <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rv    <= 1'b0;
      b_rv    <= 1'b0;
      a_wd    <= 1'b0;
      b_wd    <= 1'b0;
      a_err   <= 1'b0;
      b_err   <= 1'b0;
      a_rd    <= '0;
      b_rd    <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      we      <= we_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      rd_strt <= rd_n;
      wr_strt <= wr_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      a_ack   <= a_ack_n;
      b_ack   <= b_ack_n;
      a_rv    <= a_rv_n;
      b_rv    <= b_rv_n;
      a_wd    <= a_wd_n;
      b_wd    <= b_wd_n;
      a_err   <= a_err_n;
      b_err   <= b_err_n;
      a_rd    <= a_rd_n;
      b_rd    <= b_rd_n;
    end
  end

  assign bus.a_ack         = a_ack;
  assign bus.b_ack         = b_ack;
  assign bus.a_rvalid      = a_rv;
  assign bus.b_rvalid      = b_rv;
  assign bus.a_wdone       = a_wd;
  assign bus.b_wdone       = b_wd;
  assign bus.a_err         = a_err;
  assign bus.b_err         = b_err;
  assign bus.a_rdata       = a_rd;
  assign bus.b_rdata       = b_rd;
  assign bus.o_ctl_address = addr;
  assign bus.o_ctl_data    = wdata;
  assign bus.o_ctl_rd_strt = rd_strt;
  assign bus.o_ctl_wr_strt = wr_strt;
  assign bus.o_arb_busy    = busy;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: grant order, strobes,
// responses, watchdog abort and reset mid-transaction.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic early;

  sram_port_arbiter_if #(.ADDR_W(21), .DATA_W(16)) bus();

  sram_port_arbiter #(
    .ADDR_W(21), .DATA_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic finish_read(input logic [15:0] d);
    bus.i_ctl_data_valid = 1'b1;
    bus.i_ctl_data = d;
    tick();
    bus.i_ctl_data_valid = 1'b0;
  endtask

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.i_ctl_data = '0; bus.i_ctl_data_valid = 0;
    bus.i_ctl_wr_done = 0; bus.i_ctl_busy = 0;
    tick();
    tick();
    chk("rst_ack", {bus.a_ack, bus.b_ack}, 0);
    chk("rst_busy", bus.o_arb_busy, 0);
    chk("rst_strt", {bus.o_ctl_rd_strt, bus.o_ctl_wr_strt}, 0);
    reset = 1'b0;

    // 1: single read by A
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h1AD969;
    tick();
    chk("t1_ack", {bus.a_ack, bus.b_ack}, 2'b10);
    chk("t1_rdstrt", bus.o_ctl_rd_strt, 1);
    chk("t1_wrstrt", bus.o_ctl_wr_strt, 0);
    chk("t1_addr", bus.o_ctl_address, 21'h1AD969);
    chk("t1_busy", bus.o_arb_busy, 1);
    bus.a_req = 0;
    tick();
    chk("t1_ack_pulse", bus.a_ack, 0);
    chk("t1_strt_hold", bus.o_ctl_rd_strt, 1);
    bus.i_ctl_busy = 1;
    tick();
    chk("t1_strt_drop", bus.o_ctl_rd_strt, 0);
    repeat (7) tick();
    chk("t1_no_rv", bus.a_rvalid, 0);
    bus.i_ctl_busy = 0;
    finish_read(16'hB635);
    chk("t1_rv", {bus.a_rvalid, bus.b_rvalid, bus.a_err}, 3'b100);
    chk("t1_rdata", bus.a_rdata, 16'hB635);
    tick();
    chk("t1_rv_pulse", bus.a_rvalid, 0);
    chk("t1_idle", bus.o_arb_busy, 0);

    // 2: tie after reset -> A, then A re-requests -> B wins
    do_reset();
    bus.a_req = 1; bus.a_addr = 21'h000111;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 21'h000222;
    tick();
    chk("t2_first", {bus.a_ack, bus.b_ack}, 2'b10);
    chk("t2_addr_a", bus.o_ctl_address, 21'h000111);
    bus.a_addr = 21'h000333;
    finish_read(16'h1111);
    chk("t2_a_rv", {bus.a_rvalid, bus.b_ack}, 2'b10);
    tick();
    chk("t2_tie_b", {bus.a_ack, bus.b_ack}, 2'b01);
    chk("t2_addr_b", bus.o_ctl_address, 21'h000222);
    bus.b_req = 0;
    finish_read(16'h2222);
    chk("t2_b_rv", {bus.b_rvalid, bus.a_rvalid}, 2'b10);
    chk("t2_b_rdata", bus.b_rdata, 16'h2222);
    chk("t2_a_hold", bus.a_rdata, 16'h1111);
    tick();
    chk("t2_a_again", {bus.a_ack, bus.b_ack}, 2'b10);
    chk("t2_addr_a2", bus.o_ctl_address, 21'h000333);
    bus.a_req = 0;
    finish_read(16'h3333);
    tick();

    // 3: write by B
    bus.b_req = 1; bus.b_we = 1;
    bus.b_addr = 21'h000010; bus.b_wdata = 16'h5A5A;
    tick();
    chk("t3_ack", {bus.a_ack, bus.b_ack}, 2'b01);
    chk("t3_strt", {bus.o_ctl_rd_strt, bus.o_ctl_wr_strt}, 2'b01);
    chk("t3_data", bus.o_ctl_data, 16'h5A5A);
    chk("t3_addr", bus.o_ctl_address, 21'h000010);
    bus.b_req = 0;
    tick();
    chk("t3_strt_hold", bus.o_ctl_wr_strt, 1);
    bus.i_ctl_busy = 1;
    tick();
    chk("t3_strt_drop", bus.o_ctl_wr_strt, 0);
    bus.i_ctl_busy = 0;
    finish_read(16'hFFFF);
    chk("t3_wrong_type", {bus.b_wdone, bus.b_rvalid, bus.o_arb_busy}, 3'b001);
    bus.i_ctl_wr_done = 1;
    tick();
    bus.i_ctl_wr_done = 0;
    chk("t3_wdone", {bus.b_wdone, bus.b_err}, 2'b10);
    chk("t3_a_quiet",
        {bus.a_ack, bus.a_rvalid, bus.a_wdone, bus.a_err}, 0);
    tick();

    // 4: watchdog abort
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 21'h0ABCDE;
    tick();
    chk("t4_ack", bus.a_ack, 1);
    bus.a_req = 0;
    early = 0;
    repeat (15) begin
      tick();
      if (bus.a_rvalid | bus.a_err) early = 1;
    end
    chk("t4_early", early, 0);
    chk("t4_strt_held", bus.o_ctl_rd_strt, 1);
    tick();
    chk("t4_abort", {bus.a_rvalid, bus.a_err}, 2'b11);
    chk("t4_rdata0", bus.a_rdata, 0);
    chk("t4_strt", bus.o_ctl_rd_strt, 0);
    tick();
    chk("t4_pulse", {bus.a_rvalid, bus.a_err, bus.o_arb_busy}, 0);
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 21'h000005;
    tick();
    chk("t4_new_grant", bus.b_ack, 1);
    bus.b_req = 0;
    finish_read(16'h7777);
    tick();

    // 5: reset while in WAIT
    bus.a_req = 1; bus.a_addr = 21'h000042;
    tick();
    bus.a_req = 0;
    bus.i_ctl_busy = 1;
    tick();
    bus.i_ctl_busy = 0;
    tick();
    reset = 1;
    tick();
    chk("t5_rst_out",
        {bus.o_arb_busy, bus.o_ctl_rd_strt, bus.a_rvalid, bus.a_ack}, 0);
    chk("t5_rst_rdata", bus.b_rdata, 0);
    reset = 0;
    finish_read(16'hDEAD);
    chk("t5_late", {bus.a_rvalid, bus.b_rvalid, bus.o_arb_busy}, 0);
    bus.a_req = 1; bus.b_req = 1;
    tick();
    chk("t5_tie_a", {bus.a_ack, bus.b_ack}, 2'b10);
    bus.a_req = 0; bus.b_req = 0;
    finish_read(16'h0001);
    tick();
    tick();

    // 6: completion on the timeout cycle
    bus.a_req = 1; bus.a_addr = 21'h000077;
    tick();
    chk("t6_ack", bus.a_ack, 1);
    bus.a_req = 0;
    repeat (15) tick();
    finish_read(16'hC3C3);
    chk("t6_rv", {bus.a_rvalid, bus.a_err}, 2'b10);
    chk("t6_rdata", bus.a_rdata, 16'hC3C3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
